// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (see fetch_controller).
package fetch_pkg;

  localparam int INSTR_W     = 32;
  localparam int ADDR_W      = 64;
  localparam int FETCH_DEPTH = 2;

  // Sequencer states; FS_FAULT is only reachable with FETCH_MISALIGN_CHECK_EN.
  typedef enum logic [1:0] {
    FS_RUN   = 2'd0,
    FS_END   = 2'd1,
    FS_FAULT = 2'd2
  } fetch_state_e;

  // One buffered fetch: instruction word plus the byte address it came from.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry synchronous FIFO holding fetched words for decode.
// Flush has priority over push and pop. Push while full is accepted
// only when a pop happens in the same cycle (order is preserved).
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem [FETCH_DEPTH];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         pop_ok;
  logic         push_ok;

  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && ((count < 2'(FETCH_DEPTH)) || pop_ok);

  // Head is forced to zero when empty so out_* read zero with out_valid low.
  always_comb begin
    head = '0;
    if (count != 2'd0) head = mem[rd_ptr];
  end

  // Storage, pointers and occupancy; flush empties without touching storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FETCH_DEPTH; i++) mem[i] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, reads the combinational
// instruction memory, buffers words in fetch_buffer and hands them to decode.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN -- misaligned redirects
// trap into a sticky FAULT state instead of being silently aligned.
//
// Handshake: out_valid/out_ready follow strict valid/ready semantics. A word
// transfers on a rising edge where both are high; while out_valid is high and
// out_ready is low, out_instr/out_pc hold steady. out_valid never depends on
// out_ready. A redirect discards the buffer, including any same-cycle transfer.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int unsigned       MEM_BYTES = 16,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               done,
  output logic               fetch_fault,
  output logic [1:0]         state_dbg
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_END   = 2'd1;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic [1:0] ST_FAULT = 2'd2;
`endif

  // 65-bit comparisons so the PC+4/PC+8 checks never wrap.
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  logic [ADDR_W-1:0] pc;
  logic [1:0]        state;
  logic [ADDR_W:0]   pc_next4;
  logic [ADDR_W:0]   pc_next8;
  logic              fits_now;
  logic              pop;
  logic              push;
  logic [ADDR_W-1:0] redirect_tgt;
  logic              misaligned;
  logic [1:0]        count;
  fetch_entry_t      wr_entry;
  fetch_entry_t      head;

  assign pc_next4 = {1'b0, pc} + (ADDR_W+1)'(4);
  assign pc_next8 = {1'b0, pc} + (ADDR_W+1)'(8);
  assign fits_now = (pc_next4 <= MEM_LIMIT);

  assign pop  = out_valid && out_ready;
  assign push = (state == ST_RUN) && !redirect_valid && fits_now &&
                ((count < 2'(FETCH_DEPTH)) || pop);

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redirect_tgt = redirect_pc;
  assign misaligned   = |redirect_pc[1:0];
`else
  logic unused_low_bits;
  assign unused_low_bits = ^redirect_pc[1:0];
  assign redirect_tgt    = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign misaligned      = 1'b0;
`endif

  assign wr_entry.instr = imem_instr;
  assign wr_entry.pc    = pc;

  fetch_buffer u_buffer (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .flush    (redirect_valid),
    .wr_entry (wr_entry),
    .head     (head),
    .count    (count)
  );

  assign imem_addr = pc;
  assign out_valid = (count != 2'd0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign done      = (state == ST_END) && (count == 2'd0);
  assign state_dbg = state;

  // PC and state: redirect wins, otherwise RUN pushes until the image ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc    <= RESET_PC;
      state <= ST_RUN;
    end else if (redirect_valid) begin
      pc <= redirect_tgt;
`ifdef FETCH_MISALIGN_CHECK_EN
      state <= misaligned ? ST_FAULT : ST_RUN;
`else
      state <= ST_RUN;
`endif
    end else if (state == ST_RUN) begin
      if (!fits_now) begin
        state <= ST_END;
      end else if (push) begin
        pc <= pc_next4[ADDR_W-1:0];
        if (pc_next8 > MEM_LIMIT) state <= ST_END;
      end
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  // Sticky fault flag: set by a misaligned redirect, cleared by an aligned one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fetch_fault <= 1'b0;
    else if (redirect_valid) fetch_fault <= misaligned;
  end
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller against the 4-word test image.
module tb_fetch_controller;

  logic        clk;
  logic        reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        done;
  logic        fetch_fault;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] W0 = 32'h02853483;
  localparam logic [31:0] W1 = 32'h009A84B3;
  localparam logic [31:0] W2 = 32'h00148493;
  localparam logic [31:0] W3 = 32'h02953423;

  // Combinational instruction memory model.
  logic [31:0] image [4];
  initial begin
    image[0] = W0; image[1] = W1; image[2] = W2; image[3] = W3;
  end
  always_comb begin
    imem_instr = 32'h0;
    if (imem_addr < 64'd16) imem_instr = image[imem_addr[3:2]];
  end

  fetch_controller #(.MEM_BYTES(16), .RESET_PC(64'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .done           (done),
    .fetch_fault    (fetch_fault),
    .state_dbg      (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [63:0] pc, input logic [31:0] ins);
    chk({tag, "_valid"}, {63'b0, out_valid}, 64'd1);
    chk({tag, "_pc"}, out_pc, pc);
    chk({tag, "_instr"}, {32'b0, out_instr}, {32'b0, ins});
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    out_ready      = 1'b0;
    #1 reset = 1'b0;
    #1;
    // Reset values
    chk("rst_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_instr", {32'b0, out_instr}, 64'd0);
    chk("rst_pc", out_pc, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_fault", {63'b0, fetch_fault}, 64'd0);
    chk("rst_addr", imem_addr, 64'd0);
    chk("rst_state", {62'b0, state_dbg}, 64'd0);
    #1 reset = 1'b1;

    // Streaming with out_ready high
    out_ready = 1'b1;
    step(); chk_head("s0", 64'd0, W0);
    step(); chk_head("s1", 64'd4, W1);
    step(); chk_head("s2", 64'd8, W2);
    step(); chk_head("s3", 64'd12, W3);
    step();
    chk("s_end_valid", {63'b0, out_valid}, 64'd0);
    chk("s_end_done", {63'b0, done}, 64'd1);
    chk("s_end_addr", imem_addr, 64'd16);
    chk("s_end_state", {62'b0, state_dbg}, 64'd1);
    step();
    chk("s_end_addr_hold", imem_addr, 64'd16);

    // Backpressure: buffer fills to 2, PC stops at 8
    pulse_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk_head("bp_hold", 64'd0, W0);
    chk("bp_addr", imem_addr, 64'd8);
    out_ready = 1'b1;
    step(); chk_head("bp1", 64'd4, W1);
    step(); chk_head("bp2", 64'd8, W2);
    step(); chk_head("bp3", 64'd12, W3);
    step();
    chk("bp_done", {63'b0, done}, 64'd1);
    chk("bp_empty", {63'b0, out_valid}, 64'd0);

    // Redirect to 0 from END
    redirect_valid = 1'b1; redirect_pc = 64'd0;
    step();
    redirect_valid = 1'b0;
    chk("re0_valid", {63'b0, out_valid}, 64'd0);
    chk("re0_done", {63'b0, done}, 64'd0);
    step(); chk_head("re0_h0", 64'd0, W0);
    step(); chk_head("re0_h1", 64'd4, W1);

    // Redirect to 8 while head is pc 4
    redirect_valid = 1'b1; redirect_pc = 64'd8;
    step();
    redirect_valid = 1'b0;
    chk("re8_gap", {63'b0, out_valid}, 64'd0);
    step(); chk_head("re8_h0", 64'd8, W2);
    step(); chk_head("re8_h1", 64'd12, W3);
    step();
    chk("re8_done", {63'b0, done}, 64'd1);

    // Misaligned redirect to 6
    redirect_valid = 1'b1; redirect_pc = 64'd6;
    step();
    redirect_valid = 1'b0;
    chk("re6_gap", {63'b0, out_valid}, 64'd0);
    step();
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("re6_fault", {63'b0, fetch_fault}, 64'd1);
    chk("re6_valid", {63'b0, out_valid}, 64'd0);
    chk("re6_done", {63'b0, done}, 64'd0);
    step(); step();
    chk("re6_still", {63'b0, out_valid}, 64'd0);
    redirect_valid = 1'b1; redirect_pc = 64'd4;
    step();
    redirect_valid = 1'b0;
    chk("re4_clear", {63'b0, fetch_fault}, 64'd0);
    step(); chk_head("re4_h0", 64'd4, W1);
`else
    chk("re6_fault", {63'b0, fetch_fault}, 64'd0);
    chk_head("re6_h0", 64'd4, W1);
    step(); chk_head("re6_h1", 64'd8, W2);
`endif

    // Mid-stream reset with buffer full
    pulse_reset();
    out_ready = 1'b0;
    step(); step();
    chk_head("mr_full", 64'd0, W0);
    chk("mr_addr", imem_addr, 64'd8);
    #2 reset = 1'b0;
    #1;
    chk("mr_valid", {63'b0, out_valid}, 64'd0);
    chk("mr_addr0", imem_addr, 64'd0);
    chk("mr_outpc", out_pc, 64'd0);
    reset = 1'b1;
    out_ready = 1'b1;
    step(); chk_head("mr_h0", 64'd0, W0);
    step(); chk_head("mr_h1", 64'd4, W1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
